// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM and program counter for the 9-bit-instruction core.
// Fetches into ir, issues register/flag strobes, resolves branches via the LUT and runs the data-memory handshake.
module cpu_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      imem_data,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    output logic [3:0]      lut_idx,
    input  logic [PC_W-1:0] lut_target,
    input  logic            flag_gt,
    input  logic            flag_eq,
    output logic            reg_we,
    output logic            flag_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t          state;
    logic [4:0]      op5;
    logic            is_cmp;
    logic            is_reg;
    logic            is_jg;
    logic            is_jge;
    logic            is_jmp;
    logic            is_mem;
    logic            is_halt;
    logic            is_load;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;

    assign op5     = ir[8:4];
    assign lut_idx = ir[3:0];
    assign pc_inc  = pc + 1'b1;
    assign is_load = ~ir[3];

    // Instruction classification of the held ir; HALT is checked before the NOP fallback.
    always_comb begin
        is_cmp  = (ir[8:6] == 3'b000);
        is_reg  = ((ir[8:7] == 2'b00) && !is_cmp)
               || (ir[8:7] == 2'b01)
               || (op5 == 5'b10100) || (op5 == 5'b10101) || (op5 == 5'b10110);
        is_jg   = (op5 == 5'b10000);
        is_jge  = (op5 == 5'b10001);
        is_jmp  = (op5 == 5'b10010);
        is_mem  = (op5 == 5'b10111) || (op5 == 5'b11000);
        is_halt = (ir == 9'h1FF);
    end

    always_comb begin
        pc_next = pc_inc;
        if (is_jg && flag_gt) begin
            pc_next = lut_target;
        end else if (is_jge && (flag_gt || flag_eq)) begin
            pc_next = lut_target;
        end else if (is_jmp) begin
            pc_next = lut_target;
        end
    end

    // Strobes decode from the registered state; the load write-back coincides with the ack cycle.
    always_comb begin
        reg_we   = ((state == EXEC) && is_reg)
                || ((state == MEM) && dmem_ack && is_load);
        flag_we  = (state == EXEC) && is_cmp;
        dmem_req = (state == MEM);
        dmem_we  = (state == MEM) && ir[3];
        done     = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    ir    <= imem_data;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_halt) begin
                        state <= HALT;
                    end else if (is_mem) begin
                        state <= MEM;
                    end else begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level reference model predicts
// strobes, handshake behaviour and the next pc for directed and randomized programs.
module tb_cpu_sequencer;

    localparam int PC_W = 4;

    localparam int K_CMP  = 0;
    localparam int K_REG  = 1;
    localparam int K_JG   = 2;
    localparam int K_JGE  = 3;
    localparam int K_JMP  = 4;
    localparam int K_MEM  = 5;
    localparam int K_HALT = 6;
    localparam int K_NOP  = 7;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [8:0]      imem_data;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic [3:0]      lut_idx;
    logic [PC_W-1:0] lut_target;
    logic            flag_gt;
    logic            flag_eq;
    logic            reg_we;
    logic            flag_we;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            done;

    logic [8:0]      rom [16];
    logic [PC_W-1:0] lut [16];
    logic [PC_W-1:0] mpc;
    int              vectors;
    int              miscompares;

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_data  (imem_data),
        .pc         (pc),
        .ir         (ir),
        .lut_idx    (lut_idx),
        .lut_target (lut_target),
        .flag_gt    (flag_gt),
        .flag_eq    (flag_eq),
        .reg_we     (reg_we),
        .flag_we    (flag_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .done       (done)
    );

    assign imem_data  = rom[pc];
    assign lut_target = lut[lut_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction classes straight from the opcode table, matched by numeric ranges.
    function automatic int kind(input logic [8:0] i);
        int v;
        int top5;
        v    = int'(i);
        top5 = v / 16;
        if (v == 511)                               return K_HALT;
        if (v < 64)                                 return K_CMP;
        if (v < 256)                                return K_REG;
        if (top5 >= 20 && top5 <= 22)               return K_REG;
        if (top5 == 16)                             return K_JG;
        if (top5 == 17)                             return K_JGE;
        if (top5 == 18)                             return K_JMP;
        if (top5 == 23 || top5 == 24)               return K_MEM;
        return K_NOP;
    endfunction

    task automatic begin_run();
        rst_n    = 1'b0;
        start    = 1'b0;
        dmem_ack = 1'b0;
        flag_gt  = 1'b0;
        flag_eq  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc   = '0;
    endtask

    // Runs one instruction starting from a FETCH cycle and checks it against the model.
    task automatic step(input bit gt, input bit eq, input int wait_cycles, output bit halted);
        logic [8:0]      instr;
        logic [PC_W-1:0] npc;
        int              k;
        bit              take;
        halted = 1'b0;
        instr  = rom[mpc];
        k      = kind(instr);
        vectors++;
        if ({reg_we, flag_we, dmem_req, done} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL fetch_strobes pc=%0d: got %b expected 0000", mpc, {reg_we, flag_we, dmem_req, done});
        end
        flag_gt = gt;
        flag_eq = eq;
        @(negedge clk);
        vectors++;
        if (ir !== instr) begin
            miscompares++;
            $display("[TB] FAIL ir_load pc=%0d: got %h expected %h", mpc, ir, instr);
        end
        vectors++;
        if ({reg_we, flag_we, dmem_req, done} !== {k == K_REG, k == K_CMP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL exec_strobes ir=%h: got %b expected %b", instr,
                     {reg_we, flag_we, dmem_req, done}, {k == K_REG, k == K_CMP, 1'b0, 1'b0});
        end
        take = (k == K_JMP) || (k == K_JG && gt) || (k == K_JGE && (gt || eq));
        npc  = take ? lut[instr[3:0]] : PC_W'((int'(mpc) + 1) % 16);
        if (k == K_MEM) begin
            for (int w = 0; w <= wait_cycles; w++) begin
                @(negedge clk);
                if (w == wait_cycles) dmem_ack = 1'b1;
                #1;
                vectors++;
                if ({dmem_req, dmem_we, reg_we} !== {1'b1, instr[3], (w == wait_cycles) && !instr[3]}) begin
                    miscompares++;
                    $display("[TB] FAIL mem_cycle%0d ir=%h: got req/we/reg_we %b expected %b", w, instr,
                             {dmem_req, dmem_we, reg_we}, {1'b1, instr[3], (w == wait_cycles) && !instr[3]});
                end
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end else if (k == K_HALT) begin
            @(negedge clk);
            vectors++;
            if ({done, pc} !== {1'b1, mpc}) begin
                miscompares++;
                $display("[TB] FAIL halt_entry: got done=%b pc=%0d expected done=1 pc=%0d", done, pc, mpc);
            end
            halted = 1'b1;
            return;
        end else begin
            @(negedge clk);
        end
        vectors++;
        if ({pc, dmem_req} !== {npc, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL next_pc ir=%h: got pc=%0d req=%b expected pc=%0d req=0", instr, pc, dmem_req, npc);
        end
        mpc = npc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        dmem_ack = 1'b0;
        flag_gt  = 1'b0;
        flag_eq  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({pc, ir} !== {4'd0, 9'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: got pc=%0d ir=%h expected pc=0 ir=000", pc, ir);
        end
        vectors++;
        if ({reg_we, flag_we, dmem_req, dmem_we, done} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000", {reg_we, flag_we, dmem_req, dmem_we, done});
        end
    endtask

    task automatic test_start_mov();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = 9'h040;
        rom[0] = 9'h07A;
        begin_run();
        step(1'b0, 1'b0, 0, h);
    endtask

    task automatic test_wrap();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = 9'h040 | 9'($urandom_range(0, 63));
        begin_run();
        for (int n = 0; n < 18; n++) step(1'($urandom), 1'($urandom), 0, h);
    endtask

    task automatic test_branches();
        bit h;
        for (int i = 0; i < 16; i++) begin
            rom[i] = 9'h040;
            lut[i] = 4'd15;
        end
        rom[0] = 9'h025;
        rom[1] = 9'h103;
        rom[2] = 9'h113;
        rom[9] = 9'h125;
        lut[3] = 4'd9;
        lut[5] = 4'd2;
        begin_run();
        step(1'b1, 1'b0, 0, h);
        step(1'b1, 1'b0, 0, h);
        begin_run();
        step(1'b0, 1'b1, 0, h);
        step(1'b0, 1'b1, 0, h);
        step(1'b0, 1'b1, 0, h);
        step(1'b0, 1'b0, 0, h);
    endtask

    task automatic test_load_wait();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = 9'h040;
        rom[0] = 9'h170;
        rom[1] = 9'h188;
        begin_run();
        step(1'b0, 1'b0, 3, h);
        step(1'b0, 1'b0, 0, h);
    endtask

    task automatic test_halt();
        bit h;
        for (int i = 0; i < 16; i++) rom[i] = 9'h040;
        rom[4] = 9'h1FF;
        begin_run();
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 0, h);
        vectors++;
        if (h !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_reached: got %b expected 1", h);
        end
        for (int n = 0; n < 4; n++) begin
            start = n[0];
            @(negedge clk);
            vectors++;
            if ({done, pc, ir, reg_we, dmem_req} !== {1'b1, 4'd4, 9'h1FF, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL halt_frozen: got done=%b pc=%0d ir=%h expected done=1 pc=4 ir=1ff", done, pc, ir);
            end
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({done, pc} !== {1'b0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL halt_reset: got done=%b pc=%0d expected done=0 pc=0", done, pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        for (int i = 0; i < 16; i++) rom[i] = 9'h040;
        rom[0] = 9'h170;
        begin_run();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_mem_req: got %b expected 1", dmem_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({dmem_req, pc, done} !== {1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mid_mem_reset: got req=%b pc=%0d done=%b expected 0 0 0", dmem_req, pc, done);
        end
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        #1;
        vectors++;
        if ({reg_we, dmem_req} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL late_ack_strobe: got %b expected 00", {reg_we, dmem_req});
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({pc, ir} !== {4'd0, 9'd0}) begin
            miscompares++;
            $display("[TB] FAIL late_ack_idle: got pc=%0d ir=%h expected pc=0 ir=000", pc, ir);
        end
    endtask

    task automatic test_random();
        bit h;
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i] = 9'($urandom);
                lut[i] = 4'($urandom);
            end
            begin_run();
            h = 1'b0;
            for (int n = 0; n < 40 && !h; n++) begin
                step(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), h);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        dmem_ack    = 1'b0;
        flag_gt     = 1'b0;
        flag_eq     = 1'b0;
        mpc         = '0;
        for (int i = 0; i < 16; i++) begin
            rom[i] = 9'h040;
            lut[i] = '0;
        end
        test_reset();
        test_start_mov();
        test_wrap();
        test_branches();
        test_load_wait();
        test_halt();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM and program counter for the 9-bit-instruction core.
- Fetches from the combinational instruction ROM into an instruction register (ir), which feeds the instruction decoder.
- Classifies ir to issue register/flag write strobes, resolves jg/jge/jmp through the external 16-entry branch-target LUT, and runs the data-memory req/ack handshake for ldr/str/ldi/sti.
- Halts on the HALT opcode.

Parameters:
- PC_W, 10, program counter width; instruction memory depth is 2^PC_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  level/pulse; leaves IDLE when sampled high.
- imem_data  in  9  ROM word at address pc (combinational read).
- pc  out  PC_W  program counter.
- ir  out  9  registered current instruction, to decoder.
- lut_idx  out  4  ir[3:0], index into branch-target LUT.
- lut_target  in  PC_W  LUT entry for lut_idx (combinational).
- flag_gt  in  1  registered ALU greater-than flag.
- flag_eq  in  1  registered ALU equal flag.
- reg_we  out  1  register-file write strobe.
- flag_we  out  1  flag-register write strobe (cmp).
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  memory completion, 1-cycle pulse.
- done  out  1  program halted.

Behaviour:
- One clock domain; reset is synchronous and active-low: rst_n low at a rising clk edge forces reset regardless of state, including mid-MEM.
- Reset values: state=IDLE, pc=0, ir=0, all strobes 0, done=0.
- States: IDLE, FETCH, EXEC, MEM, HALT (one-hot or binary, implementer's choice).
- IDLE:
  - start=1 -> FETCH; otherwise hold.
  - pc unchanged.
- FETCH (1 cycle):
  - ir <= imem_data.
  - -> EXEC.
- EXEC (1 cycle): strobes are combinational from state and ir, asserted only in this state unless noted.
  - ir[8:6]=000 (cmp): flag_we=1; pc<=pc+1; -> FETCH.
  - ir[8:7]=00 with ir[8:6]!=000 (mov), or ir[8:7]=01 (two-reg ALU): reg_we=1; pc<=pc+1; -> FETCH.
  - ir[8:4]=10100, 10101, 10110 (inc..clr, not, lsr): reg_we=1; pc<=pc+1; -> FETCH.
  - ir[8:4]=10000 (jg): pc<=flag_gt ? lut_target : pc+1; -> FETCH.
  - ir[8:4]=10001 (jge): pc<=(flag_gt|flag_eq) ? lut_target : pc+1; -> FETCH.
  - ir[8:4]=10010 (jmp): pc<=lut_target; -> FETCH.
  - ir[8:4]=10111 (ldr/str) or 11000 (ldi/sti): no strobes; pc held; -> MEM.
  - ir=9'h1FF (HALT): pc held; -> HALT.
  - any other encoding: NOP; pc<=pc+1; -> FETCH.
  - Flags are sampled in EXEC only. A cmp immediately before a branch is visible because flag_we commits at the end of the cmp EXEC cycle.
- MEM:
  - dmem_req=1; dmem_we=ir[3] (0 = ldr/ldi, 1 = str/sti).
  - Stay in MEM while dmem_ack=0; no timeout.
  - On the cycle dmem_ack=1: reg_we=1 if load; pc<=pc+1; -> FETCH.
  - dmem_req drops the following cycle. dmem_ack outside MEM is ignored.
- HALT:
  - done=1; all other strobes 0; pc and ir frozen.
  - Only rst_n exits; start is ignored.
- pc arithmetic: pc+1 is modulo 2^PC_W (wraps 2^PC_W-1 -> 0). lut_target is used unmodified.
- Latency: ALU/branch/NOP = 2 cycles; memory op = 3 + wait cycles.
- Simultaneous events: start is ignored outside IDLE; rst_n has priority over every transition.

Test Plan:
- Reset and start:
  - Hold rst_n=0 for 2 cycles with start=1 -> pc=0, done=0, all strobes 0.
  - Release rst_n, pulse start -> ir=imem[0] after FETCH; reg_we seen in EXEC for a mov at address 0.
- Straight-line wrap:
  - PC_W=4, ROM filled with mov.
  - -> pc steps 0..15 then wraps to 0; reg_we pulses every 2nd cycle.
- Branches:
  - cmp then jg idx 3, lut[3]=9, flag_gt=1 -> pc=9.
  - Repeat with flag_gt=0, flag_eq=1 -> jg falls through to pc+1; jge to idx 3 goes to 9.
  - jmp idx 5, lut[5]=2 -> pc=2.
- Load with wait:
  - ldr; dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we=1 only on the ack cycle, pc+1 afterwards.
  - sti with same-cycle ack -> dmem_we=1, dmem_req high 1 cycle, reg_we never set.
- Halt:
  - 9'h1FF at address 4 -> done=1 from the cycle after its EXEC onward, pc=4 frozen, start pulses ignored; rst_n low clears done to 0.
- Reset mid-MEM:
  - Assert rst_n=0 while dmem_req=1 and ack pending -> next cycle state=IDLE, dmem_req=0, pc=0; a late dmem_ack is ignored.
